// File: rtl/lcd_power_sequencer.sv
// LCD panel power sequencer (pixel-clock domain).
// Sequences the panel reset, enables the timing generators and waits for a few
// frames. It then ramps the backlight PWM duty toward the requested level.
// Loss of PLL lock forces a safe OFF state and raises a sticky fault.
module lcd_power_sequencer #(
  parameter int T_RST_LOW     = 1000,
  parameter int T_RST_WAIT    = 50000,
  parameter int SETTLE_FRAMES = 2,
  parameter int RAMP_STEP     = 1024,
  parameter int PWM_BITS      = 8
) (
  input  logic                lcd_clk,
  input  logic                sys_rst_n,
  input  logic                enable,
  input  logic                pll_locked,
  input  logic                lcd_vs,
  input  logic [PWM_BITS-1:0] bl_target,
  output logic                lcd_rst_n,
  output logic                timing_en,
  output logic                lcd_bl,
  output logic                ready,
  output logic                fault,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_RST_LOW  = 3'd1,
    S_RST_WAIT = 3'd2,
    S_SETTLE   = 3'd3,
    S_RAMP_UP  = 3'd4,
    S_ON       = 3'd5,
    S_RAMP_DN  = 3'd6
  } state_t;

  localparam logic [31:0] RST_LOW_LAST  = 32'(T_RST_LOW - 1);
  localparam logic [31:0] RST_WAIT_LAST = 32'(T_RST_WAIT - 1);
  localparam logic [7:0]  FRAME_LAST    = 8'(SETTLE_FRAMES - 1);
  localparam logic [15:0] STEP_LAST     = 16'(RAMP_STEP - 1);
  localparam logic [PWM_BITS-1:0] DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  state_t              cur;
  state_t              nxt;
  logic [31:0]         cyc_cnt;
  logic [7:0]          frame_cnt;
  logic [15:0]         step_cnt;
  logic                vs_d;
  logic                vs_edge;
  logic                in_ramp;
  logic                duty_at_tgt;
  logic                step_fire;
  logic                fault_nx;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_tgt;
  logic [PWM_BITS-1:0] duty_step;
  logic [PWM_BITS-1:0] duty_nx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_nx;

  // vs_d is held at 0 outside SETTLE, so VS already high on entry counts as an edge.
  assign vs_edge     = ~vs_d & lcd_vs;
  assign in_ramp     = (cur == S_RAMP_UP) || (cur == S_ON) || (cur == S_RAMP_DN);
  assign duty_tgt    = (cur == S_RAMP_DN) ? DUTY_ZERO : bl_target;
  assign duty_at_tgt = (duty == duty_tgt);
  assign step_fire   = in_ramp && !duty_at_tgt && (step_cnt == STEP_LAST);
  assign pwm_nx      = pwm_cnt + DUTY_ONE;
  assign state       = cur;

  // Next-state, next-duty and fault logic; PLL loss overrides every other decision.
  always_comb begin
    nxt       = cur;
    fault_nx  = fault;
    duty_step = duty;
    duty_nx   = duty;
    case (cur)
      S_OFF: begin
        if (enable && pll_locked && !fault) nxt = S_RST_LOW;
        else nxt = S_OFF;
      end
      S_RST_LOW: begin
        if (!enable) nxt = S_OFF;
        else if (cyc_cnt == RST_LOW_LAST) nxt = S_RST_WAIT;
        else nxt = S_RST_LOW;
      end
      S_RST_WAIT: begin
        if (!enable) nxt = S_OFF;
        else if (cyc_cnt == RST_WAIT_LAST) nxt = S_SETTLE;
        else nxt = S_RST_WAIT;
      end
      S_SETTLE: begin
        if (!enable) nxt = S_RAMP_DN;
        else if (vs_edge && (frame_cnt == FRAME_LAST)) nxt = S_RAMP_UP;
        else nxt = S_SETTLE;
      end
      S_RAMP_UP: begin
        if (!enable) nxt = S_RAMP_DN;
        else if (duty == bl_target) nxt = S_ON;
        else nxt = S_RAMP_UP;
      end
      S_ON: begin
        if (!enable) nxt = S_RAMP_DN;
        else nxt = S_ON;
      end
      S_RAMP_DN: begin
        if (duty == DUTY_ZERO) nxt = S_OFF;
        else nxt = S_RAMP_DN;
      end
      default: nxt = S_OFF;
    endcase

    // One LSB toward the target per step, saturating at both ends.
    if (step_fire) begin
      if (duty < duty_tgt) duty_step = (duty != DUTY_MAX) ? duty + DUTY_ONE : duty;
      else duty_step = (duty != DUTY_ZERO) ? duty - DUTY_ONE : duty;
    end else begin
      duty_step = duty;
    end

    if ((cur != S_OFF) && !pll_locked) begin
      nxt      = S_OFF;
      fault_nx = 1'b1;
    end else if (!enable) begin
      fault_nx = 1'b0;
    end else begin
      fault_nx = fault;
    end

    // The backlight is never lit outside the ramp/on states.
    if (nxt inside {S_OFF, S_RST_LOW, S_RST_WAIT, S_SETTLE}) duty_nx = DUTY_ZERO;
    else duty_nx = duty_step;
  end

  // State register with output decode taken from the next state so outputs align with state.
  always_ff @(posedge lcd_clk) begin
    if (!sys_rst_n) begin
      cur       <= S_OFF;
      lcd_rst_n <= 1'b0;
      timing_en <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur       <= nxt;
      lcd_rst_n <= !((nxt == S_OFF) || (nxt == S_RST_LOW));
      timing_en <= (nxt == S_SETTLE) || (nxt == S_RAMP_UP) || (nxt == S_ON) || (nxt == S_RAMP_DN);
      ready     <= (nxt == S_ON);
      fault     <= fault_nx;
    end
  end

  // Cycle, frame and step counters; all clear whenever the state changes.
  always_ff @(posedge lcd_clk) begin
    if (!sys_rst_n) begin
      cyc_cnt   <= 32'd0;
      frame_cnt <= 8'd0;
      step_cnt  <= 16'd0;
      vs_d      <= 1'b0;
    end else begin
      vs_d <= (cur == S_SETTLE) ? lcd_vs : 1'b0;
      if (nxt != cur) begin
        cyc_cnt   <= 32'd0;
        frame_cnt <= 8'd0;
        step_cnt  <= 16'd0;
      end else begin
        cyc_cnt   <= cyc_cnt + 32'd1;
        frame_cnt <= (vs_edge && (cur == S_SETTLE)) ? frame_cnt + 8'd1 : frame_cnt;
        step_cnt  <= (step_fire || duty_at_tgt || !in_ramp) ? 16'd0 : step_cnt + 16'd1;
      end
    end
  end

  // Backlight duty and free-running PWM; lcd_bl reflects the compare of the new register values.
  always_ff @(posedge lcd_clk) begin
    if (!sys_rst_n) begin
      duty    <= DUTY_ZERO;
      pwm_cnt <= DUTY_ZERO;
      lcd_bl  <= 1'b0;
    end else begin
      duty    <= duty_nx;
      pwm_cnt <= pwm_nx;
      lcd_bl  <= (pwm_nx < duty_nx);
    end
  end

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Self-checking bench for lcd_power_sequencer using a due-cycle scoreboard.
module tb_lcd_power_sequencer;

  localparam int PB = 4;

  logic          lcd_clk = 1'b0;
  logic          sys_rst_n;
  logic          enable;
  logic          pll_locked;
  logic          lcd_vs;
  logic [PB-1:0] bl_target;
  logic          lcd_rst_n;
  logic          timing_en;
  logic          lcd_bl;
  logic          ready;
  logic          fault;
  logic [2:0]    state;

  lcd_power_sequencer #(
    .T_RST_LOW(4), .T_RST_WAIT(8), .SETTLE_FRAMES(2), .RAMP_STEP(2), .PWM_BITS(PB)
  ) dut (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .enable(enable), .pll_locked(pll_locked),
    .lcd_vs(lcd_vs), .bl_target(bl_target), .lcd_rst_n(lcd_rst_n), .timing_en(timing_en),
    .lcd_bl(lcd_bl), .ready(ready), .fault(fault), .state(state)
  );

  initial forever #5 lcd_clk = ~lcd_clk;

  // kind 0: compare output vector {state,lcd_rst_n,timing_en,ready,fault,lcd_bl} under mask
  // kind 1: compare number of lcd_bl high samples over the last 16 samples
  typedef struct {
    int         due;
    int         kind;
    string      tag;
    logic [7:0] exp;
    logic [7:0] mask;
  } exp_t;

  localparam logic [7:0] M_ALL  = 8'hFF;
  localparam logic [7:0] M_NOBL = 8'hFE;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] bl_hist = 16'd0;
  logic [7:0]  obs;

  function automatic logic [7:0] vec(input logic [2:0] st, input logic rn, input logic te,
                                     input logic rdy, input logic flt, input logic bl);
    return {st, rn, te, rdy, flt, bl};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic expect_vec(input int ofs, input string tag, input logic [7:0] e, input logic [7:0] m);
    exp_t item;
    item.due = cyc + ofs; item.kind = 0; item.tag = tag; item.exp = e; item.mask = m;
    sb.push_back(item);
  endtask

  task automatic expect_bl(input int ofs, input string tag, input int cnt);
    exp_t item;
    item.due = cyc + ofs; item.kind = 1; item.tag = tag; item.exp = 8'(cnt); item.mask = M_ALL;
    sb.push_back(item);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge lcd_clk);
  endtask

  always @(posedge lcd_clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples at the falling edge and retires every entry due now.
  always @(negedge lcd_clk) begin
    obs = {state, lcd_rst_n, timing_en, ready, fault, lcd_bl};
    bl_hist = {bl_hist[14:0], lcd_bl};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].kind == 0) check_eq(sb[i].tag, {8'd0, obs & sb[i].mask}, {8'd0, sb[i].exp & sb[i].mask});
        else check_eq(sb[i].tag, 16'($countones(bl_hist)), {8'd0, sb[i].exp});
        sb.delete(i);
      end
    end
  end

  // Power-up: 4 cycles RST_LOW, 8 cycles RST_WAIT, then SETTLE with timing enabled.
  task automatic power_up();
    for (int i = 1; i <= 4; i++) expect_vec(i, "rst_low", vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    for (int i = 5; i <= 12; i++) expect_vec(i, "rst_wait", vec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    expect_vec(13, "settle_entry", vec(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(13);
  endtask

  // Two VS pulses; RAMP_UP starts right after the second rising edge.
  task automatic settle_pulses(input int tgt);
    bl_target = PB'(tgt);
    lcd_vs = 1'b1;
    expect_vec(1, "settle_edge1", vec(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(1);
    lcd_vs = 1'b0;
    expect_vec(1, "settle_gap", vec(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(1);
    lcd_vs = 1'b1;
    expect_vec(1, "ramp_entry", vec(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_NOBL);
    tick(1);
    lcd_vs = 1'b0;
  endtask

  // From the first RAMP_UP sample: one LSB per 2 cycles from 0, then ON once duty equals target.
  task automatic ramp_to_on(input int tgt);
    for (int i = 1; i <= 2 * tgt; i++) expect_vec(i, "ramp_up", vec(3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_NOBL);
    expect_vec(2 * tgt + 1, "on_entry", vec(3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), M_NOBL);
    tick(2 * tgt + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; enable = 1'b0; pll_locked = 1'b1; lcd_vs = 1'b0; bl_target = 4'd0;
    tick(3);
    expect_vec(1, "reset", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(1);

    // 1. Power-up sequence timing.
    sys_rst_n = 1'b1; enable = 1'b1;
    power_up();

    // 2. Settle and ramp to 3; steady duty 3 gives 3 high of 16.
    settle_pulses(3);
    ramp_to_on(3);
    expect_bl(16, "bl_duty3", 3);
    tick(16);

    // 3. Track target down to 1, up to 15, back to 3 while staying ready.
    bl_target = 4'd1;
    for (int i = 1; i <= 6; i++) expect_vec(i, "on_track_dn", vec(3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), M_NOBL);
    tick(6);
    expect_bl(16, "bl_duty1", 1);
    tick(16);
    bl_target = 4'd15;
    expect_vec(1, "on_track_up", vec(3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), M_NOBL);
    tick(30);
    expect_bl(16, "bl_duty15", 15);
    tick(16);
    bl_target = 4'd3;
    tick(26);
    expect_bl(16, "bl_duty3b", 3);
    tick(16);

    // 4. Drop enable in ON at duty 3: ramp down then OFF.
    enable = 1'b0;
    for (int i = 1; i <= 7; i++) expect_vec(i, "ramp_dn", vec(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_NOBL);
    expect_vec(8, "off_after_dn", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(8);
    for (int i = 1; i <= 3; i++) expect_vec(i, "off_idle", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(3);

    // 5. PLL loss during RAMP_UP, sticky fault, clear with enable low, restart.
    enable = 1'b1;
    power_up();
    settle_pulses(3);
    tick(1);
    pll_locked = 1'b0;
    expect_vec(1, "pll_loss", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    tick(1);
    pll_locked = 1'b1;
    for (int i = 1; i <= 5; i++) expect_vec(i, "fault_hold", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), M_ALL);
    tick(5);
    enable = 1'b0;
    expect_vec(1, "fault_clear", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(1);
    enable = 1'b1;
    power_up();
    settle_pulses(3);
    ramp_to_on(3);

    // 6. Reset pulse in ON, restart, then enable drop inside RST_LOW.
    sys_rst_n = 1'b0;
    expect_vec(1, "reset_in_on", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(1);
    sys_rst_n = 1'b1;
    expect_vec(1, "restart_rst_low", vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    expect_vec(2, "restart_rst_low2", vec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(2);
    enable = 1'b0;
    expect_vec(1, "abort_rst_low", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(1);

    // Target already equal at RAMP_UP entry: ON immediately; zero duty keeps backlight dark.
    enable = 1'b1;
    power_up();
    settle_pulses(0);
    ramp_to_on(0);
    expect_bl(16, "bl_duty0", 0);
    tick(16);
    enable = 1'b0;
    expect_vec(1, "dn_at_zero", vec(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), M_ALL);
    expect_vec(2, "off_at_zero", vec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), M_ALL);
    tick(2);

    tick(2);
    check_eq("sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
